// File: rtl/mic_adc_capture.sv
// mic_adc_capture
//   Capture front end for the signal-delay block. A free-running sample timer
//   starts one conversion every SAMPLE_PERIOD cycles. Each conversion reads
//   one SPI mode-0, MSB-first frame from an external microphone ADC. The top
//   DATA_WIDTH bits of the frame are presented on mic_signal together with a
//   one-cycle wr strobe.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   capture enable; the timer is held at 0 while low
//   adc_miso   in   serial data from the ADC
//   adc_sclk   out  ADC serial clock (registered)
//   adc_cs_n   out  ADC chip select, active low (registered)
//   mic_signal out  latest sample, held between strobes
//   wr         out  one-cycle strobe: mic_signal updated
//   busy       out  frame in progress (chip select asserted)
//   overrun    out  sticky: a tick arrived while a frame was still running
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ADC deselected, waiting for the sample tick
// SETUP | cs_n low, sclk low for CLK_DIV cycles before the first bit
// SHIFT | ADC_BITS bit periods: CLK_DIV cycles low, then CLK_DIV cycles high
// DONE  | one cycle: deselect, publish the sample, pulse wr
module mic_adc_capture #(
    parameter int CLK_DIV       = 4,
    parameter int ADC_BITS      = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int SAMPLE_PERIOD = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  adc_miso,
    output logic                  adc_sclk,
    output logic                  adc_cs_n,
    output logic [DATA_WIDTH-1:0] mic_signal,
    output logic                  wr,
    output logic                  busy,
    output logic                  overrun
);

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;

    localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(ADC_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [TW-1:0]       tmr;
    logic                tick;
    logic [1:0]          state;
    logic [DW-1:0]       div_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [ADC_BITS-1:0] shift;

    assign tick = en && (tmr == TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (!en || tmr == TMR_LAST) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 1'b1;
        end
    end

    // Outputs are assigned on the transitions into each state so that every
    // pin comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            adc_sclk   <= 1'b0;
            adc_cs_n   <= 1'b1;
            mic_signal <= '0;
            wr         <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wr <= 1'b0;

            // A tick outside IDLE (DONE included) is dropped and flagged.
            if (tick && state != S_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state    <= S_SETUP;
                        adc_cs_n <= 1'b0;
                        adc_sclk <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= DIV_LAST;
                    end
                end

                S_SETUP: begin
                    if (div_cnt == '0) begin
                        state   <= S_SHIFT;
                        div_cnt <= DIV_LAST;
                        bit_cnt <= BIT_LAST;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else if (!adc_sclk) begin
                        // sclk rises on this edge; capture the bit here.
                        adc_sclk <= 1'b1;
                        div_cnt  <= DIV_LAST;
                        shift    <= {shift[ADC_BITS-2:0], adc_miso};
                    end else if (bit_cnt == '0) begin
                        state      <= S_DONE;
                        adc_sclk   <= 1'b0;
                        adc_cs_n   <= 1'b1;
                        busy       <= 1'b0;
                        wr         <= 1'b1;
                        mic_signal <= shift[ADC_BITS-1 -: DATA_WIDTH];
                    end else begin
                        adc_sclk <= 1'b0;
                        div_cnt  <= DIV_LAST;
                        bit_cnt  <= bit_cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mic_adc_capture.md
# mic_adc_capture

Front-end capture stage that feeds the signal-delay block. It paces conversions from a fixed sample-period timer and reads one frame per period from an external serial (SPI-mode-0, MSB-first) microphone ADC. It presents the top bits of each conversion as an 8-bit sample, together with a one-cycle write strobe. `mic_signal` and `wr` connect directly to the delay stage's `mic_signal` and `wr` inputs.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per `adc_sclk` half-period (≥1).
- `ADC_BITS`, 12: bits per ADC frame (≥ `DATA_WIDTH`).
- `DATA_WIDTH`, 8: output sample width.
- `SAMPLE_PERIOD`, 1024: `clk` cycles between conversion starts.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  capture enable.
- `adc_miso`  in  1  serial data from ADC.
- `adc_sclk`  out  1  ADC serial clock.
- `adc_cs_n`  out  1  ADC chip select, active-low.
- `mic_signal`  out  `DATA_WIDTH`  latest sample, held between strobes.
- `wr`  out  1  one-cycle strobe: new `mic_signal` valid.
- `busy`  out  1  high while a frame is in progress (`cs_n` low).
- `overrun`  out  1  sticky: a tick arrived while a frame was still in progress.

## Operation
- Sample timer, `$clog2(SAMPLE_PERIOD)` bits:
  - counts 0..`SAMPLE_PERIOD`-1 while `en`=1, then wraps;
  - held at 0 while `en`=0;
  - `tick` = (count == `SAMPLE_PERIOD`-1) && `en`.
- FSM states: IDLE → SETUP → SHIFT → DONE → IDLE.
  - IDLE: `cs_n`=1, `sclk`=0. On `tick`, go to SETUP.
  - SETUP: `cs_n`=0, `sclk`=0 for `CLK_DIV` cycles, then go to SHIFT.
  - SHIFT: `ADC_BITS` bit periods. Each period is `CLK_DIV` cycles `sclk`=0 followed by `CLK_DIV` cycles `sclk`=1.
    - `adc_miso` is shifted into an `ADC_BITS` shift register (MSB first) on the edge where `sclk` goes 0→1.
    - After the last high phase, go to DONE.
  - DONE (one cycle):
    - `cs_n`=1, `sclk`=0;
    - `mic_signal` ← shift[`ADC_BITS`-1 : `ADC_BITS`-`DATA_WIDTH`] (truncation, no rounding; offset-binary passed unchanged);
    - `wr`=1;
    - go to IDLE.
- `busy` = state ∈ {SETUP, SHIFT}.
- `tick` while not IDLE: the tick is dropped, `overrun` is set to 1 and stays 1 until `rst`, and the frame in progress continues unaffected.
- `en` falling mid-frame: the frame completes and its `wr` is issued. The timer clears to 0. No new frame starts until `en`=1 and a full `SAMPLE_PERIOD` has elapsed.
- `tick` in the same cycle as DONE: DONE is not IDLE, so this counts as an overrun.
- Frame length F = `CLK_DIV` + 2·`CLK_DIV`·`ADC_BITS` + 1 cycles. The integrator guarantees `SAMPLE_PERIOD` > F + 1; otherwise `overrun` flags the violation.

## Timing
- Reset values, applied immediately (asynchronous) and held until `rst` falls:
  - `adc_cs_n`=1, `adc_sclk`=0, `mic_signal`=0, `wr`=0, `busy`=0, `overrun`=0;
  - FSM in IDLE, timer 0, shift register 0.
- `rst` mid-frame: the frame is aborted, no `wr` is issued, and the ADC is deselected at once.
- First `tick` occurs in the `SAMPLE_PERIOD`-th cycle with `en`=1, counting from the first such cycle.
- With `tick` in cycle T:
  - `adc_cs_n` falls at T+1;
  - first `sclk` rise at T+1+2·`CLK_DIV`;
  - `wr`=1 and new `mic_signal` in cycle T+F, which is T+101 at defaults. `adc_cs_n` rises in the same cycle.
- All outputs are registered and glitch-free. `wr` is high for exactly one cycle per completed frame.
- Steady state produces one `wr` every `SAMPLE_PERIOD` cycles.

## Test plan
- Reset then `en`=1, ADC model returns 12'hA5C → `cs_n` falls at cycle 1024; `wr` at cycle 1024+101; `mic_signal`=8'hA5; exactly 12 `sclk` rising edges.
- Continuous `en`, ADC returns 12'hFFF then 12'h00F → `wr` pulses exactly 1024 cycles apart; `mic_signal` = 8'hFF, then 8'h00.
- `SAMPLE_PERIOD`=64, defaults otherwise (F=101) → every second tick is dropped, `overrun`=1 after the first dropped tick, `wr` every 128 cycles.
- `en` dropped at cycle T+50 of a frame → `wr` still at T+101. Then `en` high at cycle E → next `cs_n` fall at E+1024.
- `rst` pulsed at T+60 (asynchronous, mid-cycle) → `cs_n`=1 and `sclk`=0 the same instant, no `wr`, `mic_signal`=0, `overrun`=0.
- `CLK_DIV`=1, `ADC_BITS`=8, `SAMPLE_PERIOD`=32, ADC returns 8'h3C → `wr` at T+18; `mic_signal`=8'h3C; `sclk` period is 2 cycles.
